// File: rtl/event_flasher.sv
// Turns single-cycle event strobes into visible flashes of ON_TICKS high and
// GAP_TICKS low. Events that arrive mid-flash are queued and replayed in order.
module event_flasher #(
    parameter int ON_TICKS  = 25,
    parameter int GAP_TICKS = 25,
    parameter int PEND_W    = 3
) (
    input  logic              clock_10ms,
    input  logic              reset,
    input  logic              eventPulse,
    input  logic              clear,
    output logic              flashOut,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PEND_W-1:0] pending_q;
    logic              overflow_q;
    logic              flash_q;
    logic              busy_q;

    // cnt_q holds the remaining cycles in the current state; zero marks the last one.
    always_ff @(posedge clock_10ms) begin
        if (reset || clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            flash_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eventPulse) begin
                        state_q <= ON;
                        cnt_q   <= ON_LOAD;
                        flash_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ON: begin
                    if (eventPulse) begin
                        if (pending_q != PEND_MAX) pending_q  <= pending_q + 1'b1;
                        else                       overflow_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= GAP;
                        cnt_q   <= GAP_LOAD;
                        flash_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (eventPulse) begin
                            if (pending_q != PEND_MAX) pending_q  <= pending_q + 1'b1;
                            else                       overflow_q <= 1'b1;
                        end
                    end else if (pending_q != '0 || eventPulse) begin
                        // A pulse on the final gap cycle cancels the dequeue instead of queuing.
                        state_q <= ON;
                        cnt_q   <= ON_LOAD;
                        flash_q <= 1'b1;
                        if (pending_q != '0 && !eventPulse) pending_q <= pending_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    flash_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flashOut = flash_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: doc/event_flasher.md
# event_flasher

Converts single-cycle event pulses (e.g. a debounced key-press strobe) into human-visible flashes on an LED or buzzer output, one flash per event. It sits on the output side of the calculator UI and queues events that arrive while a flash is in progress, so bursts are replayed as distinct flashes rather than merged or lost. It runs on the 10 ms system clock, so all durations are expressed in 10 ms ticks.

## Interface
Parameters:
- ON_TICKS, 25: cycles `flashOut` is held high per event (250 ms); must be ≥ 1.
- GAP_TICKS, 25: minimum low cycles after each flash (250 ms); must be ≥ 1.
- PEND_W, 3: width of the pending-event counter; the counter saturates at 2^PEND_W − 1.

Ports:
- clock_10ms, input, 1: system clock; the only clock in the block.
- reset, input, 1: synchronous, active-high reset.
- eventPulse, input, 1: one-cycle event strobe; each high cycle is one event.
- clear, input, 1: synchronous abort; discards the current flash and all queued events.
- flashOut, output, 1: registered indicator drive.
- busy, output, 1: high whenever the state is not IDLE.
- pending, output, PEND_W: number of queued events not yet flashed, excluding the one currently flashing.
- overflow, output, 1: sticky flag; set when an event is dropped because `pending` is saturated.

## Operation
- States:
  - IDLE: `flashOut` = 0.
  - ON: `flashOut` = 1 for ON_TICKS cycles.
  - GAP: `flashOut` = 0 for GAP_TICKS cycles.
- Tick counter: sized to hold max(ON_TICKS, GAP_TICKS). It is loaded on each state entry and counts down.
- Priority, highest first: `reset`, then `clear`, then normal operation.
- On `reset` or `clear`:
  - state → IDLE; `flashOut`, `busy`, `pending`, `overflow` → 0.
  - An `eventPulse` in the same cycle is discarded.
- IDLE with `eventPulse`=1: go to ON; `pending` is unchanged at 0.
- ON, last cycle: go to GAP.
- ON or GAP with `eventPulse`=1, and not the last GAP cycle:
  - If `pending` < max: `pending` += 1.
  - Otherwise `pending` holds and `overflow` is set to 1.
- GAP, last cycle:
  - `pending` > 0: go to ON and decrement `pending`. If `eventPulse` is also high, `pending` stays the same (net zero) and `overflow` is not set, even at saturation.
  - `pending` = 0 and `eventPulse`=1: go to ON; `pending` stays 0.
  - Otherwise: go to IDLE.
- Every event that is not dropped produces exactly one flash, in arrival order.
- `eventPulse` held high for N cycles counts as N events.

## Timing
- Reset values: `flashOut`=0, `busy`=0, `pending`=0, `overflow`=0, state IDLE.
- Latency: `eventPulse` sampled high at edge k while in IDLE gives `flashOut`=1 and `busy`=1 from edge k onward (registered, one-cycle latency).
- Each flash: `flashOut` high for exactly ON_TICKS consecutive cycles, then low for exactly GAP_TICKS cycles before the next flash.
- Back-to-back flashes therefore have period ON_TICKS + GAP_TICKS.
- After the final GAP, `busy` drops at the edge the state returns to IDLE, GAP_TICKS cycles after `flashOut` falls.
- `pending` and `overflow` update on the same edge as the event that changes them.
- `clear` or `reset` mid-flash: `flashOut` is 0 at the very next edge, with no truncated-gap wait.

## Test plan
All scenarios use ON_TICKS=3, GAP_TICKS=2, PEND_W=2.

- Reset: hold `reset` for 2 cycles with `eventPulse`=1 → all outputs 0 and no flash after `reset` is released.
- Single event: one `eventPulse` in IDLE →
  - `flashOut` high for cycles 1–3 after the pulse edge, low for cycles 4–5.
  - `busy` falls at cycle 5; `pending` stays 0.
- Burst: 3 pulses on consecutive cycles →
  - `pending` reads 1 then 2.
  - Three flashes of 3 cycles high / 2 cycles low.
  - `pending` decrements at each GAP end; `busy` is high for 15 cycles total.
- Overflow: 5 pulses during the first flash →
  - `pending` saturates at 3 and `overflow` goes to 1.
  - Exactly 4 flashes are produced; `overflow` stays 1 until `clear`.
- Boundary: with `pending`=3, pulse on the last GAP cycle → `pending` stays 3, `overflow` stays 0, next ON starts. Separately, with `pending`=0, pulse on the last GAP cycle → ON follows with no IDLE cycle.
- Clear: `clear` together with `eventPulse` during the second ON cycle with `pending`=2 →
  - `flashOut`=0, `pending`=0, `busy`=0 at the next edge.
  - No further flashes.
